gnl_sync_fifo: RTL and testbench
================================

GNL_SYNC_FIFO -- requirements
Module: gnl_sync_fifo

Interface
REQ-001 The block SHALL take parameter DW, default 32: data width in bits.
REQ-002 The block SHALL take parameter DP, default 4: depth in entries; power of two, at least 2.
REQ-003 The block SHALL take parameter AW, default log2(DP): pointer index width.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous clear of all entries.
REQ-007 i_vld  input  1  write-side valid.
REQ-008 i_rdy  output  1  write-side ready; high means not full.
REQ-009 i_dat  input  DW  write-side data.
REQ-010 o_vld  output  1  read-side valid; high means not empty.
REQ-011 o_rdy  input  1  read-side ready.
REQ-012 o_dat  output  DW  read-side data, taken from the head entry.
REQ-013 o_cnt  output  AW+1  current occupancy, 0..DP.

Function
REQ-014 The block SHALL perform a push when i_vld and i_rdy are both high at a rising edge, and SHALL perform a pop when o_vld and o_rdy are both high at a rising edge.
REQ-015 The block SHALL keep a write pointer and a read pointer, each AW+1 bits wide, with the MSB as the wrap bit; each pointer increments modulo 2*DP on its own transfer.
REQ-016 The block SHALL report empty when the two pointers are fully equal, and SHALL report full when the index bits are equal and the wrap bits differ.
REQ-017 The block SHALL drive i_rdy = !full and o_vld = !empty, both as direct functions of registered pointers; neither SHALL depend combinationally on i_vld or o_rdy.
REQ-018 The block SHALL drive o_dat combinationally from the storage entry at the read index (first-word fall-through); o_dat is don't-care while o_vld is low.
REQ-019 The block SHALL have a latency of 1 cycle: data pushed at edge N appears with o_vld high after edge N; there is no same-cycle bypass from i_dat to o_dat.
REQ-020 On a simultaneous push and pop, the block SHALL keep o_cnt unchanged and advance both pointers.
REQ-021 When full, the block SHALL hold i_rdy low even if o_rdy is high in the same cycle; a pop frees the slot for the next cycle.
REQ-022 The block SHALL drive o_cnt as write pointer minus read pointer, modulo 2*DP, in AW+1 bits.
REQ-023 The block SHALL write storage entries only on a push; entries have no reset and are written only at the write index.
REQ-024 flush SHALL set both pointers to 0 at the edge and override any push or pop in the same cycle; after that edge o_vld=0, i_rdy=1, o_cnt=0.
REQ-025 Pointer wrap-around SHALL be seamless: after 2*DP pushes and pops, the pointers return to 0 with no gap or stall.

Reset
REQ-026 Reset SHALL asynchronously clear both pointers to 0, giving o_vld=0, i_rdy=1 and o_cnt=0 while rst_n is low and after it is released.
REQ-027 Assertion of reset mid-operation SHALL discard all contents immediately; storage entries keep stale values but are unreachable.
REQ-028 No output SHALL glitch to X after reset; o_dat is exempt while o_vld=0.

Structure
REQ-029 DP/AW derivation and the default widths SHALL live in the shared general-library package header.
REQ-030 Pointer registers SHALL be built from the existing general-library reset DFF with load-enable (reset value 0); storage SHALL use the load-enable DFF without reset, one instance per entry.
REQ-031 One sub-module, gnl_fifo_ptr, is natural and SHALL be used: an AW+1-bit wrap pointer with inc and clr inputs, instantiated twice.

Verification
REQ-032 DP=4, DW=32: push 0x11,0x22,0x33,0x44 with o_rdy=0 -> i_rdy low after the 4th edge, o_cnt=4, o_dat=0x11.
REQ-033 From full, hold o_rdy=1 and i_vld=1 -> first cycle pops only; next cycle push and pop together, o_cnt stays 3; output order 0x11,0x22,0x33,0x44.
REQ-034 From empty, push 0xA5 at edge N with o_rdy=1 -> o_vld low before N, high for exactly one cycle after N with o_dat=0xA5, then low.
REQ-035 Run 20 back-to-back push+pop cycles with an incrementing pattern -> output is the identical sequence, o_cnt is constant, both pointers wrap twice with no stall.
REQ-036 Assert flush with 3 entries while i_vld=1 and o_rdy=1 -> after the edge o_cnt=0, o_vld=0, i_rdy=1, and the pushed word is discarded.
REQ-037 Drop rst_n asynchronously mid-cycle with 2 entries -> o_vld=0 and o_cnt=0 immediately; after release, the first push returns its own data, not stale data.

Source files
------------

// File: rtl/gnl_sync_fifo_pkg.sv
// Shared general-library definitions for the synchronous FIFO: default widths
// and the depth-to-index-width derivation.
package gnl_sync_fifo_pkg;

  localparam int GNL_DW_DEF = 32;
  localparam int GNL_DP_DEF = 4;

  // Index width for a power-of-two depth; a depth of 1 still needs one bit.
  function automatic int gnl_aw(input int dp);
    return (dp <= 1) ? 1 : $clog2(dp);
  endfunction

endpackage

// File: rtl/gnl_dff.sv
// General-library flops: load-enable DFF with async active-low reset, and
// load-enable DFF without reset for storage arrays.

// Resettable load-enable flop.
module gnl_dffre #(
  parameter int           W  = 1,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State register with async clear to RV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RV;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// Non-reset load-enable flop.
module gnl_dffe #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage register, loads only when enabled.
  always_ff @(posedge clk) begin
    if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/gnl_sync_fifo_ptr.sv
// Wrap pointer for the FIFO: AW index bits plus an MSB wrap bit, counting
// modulo 2*DP. clr wins over inc.
module gnl_fifo_ptr
  import gnl_sync_fifo_pkg::*;
#(
  parameter int AW = gnl_aw(GNL_DP_DEF)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] ptr
);

  logic [AW:0] ptr_d;
  logic [AW:0] ptr_q;
  logic        ptr_en;

  // Next-pointer selection; natural overflow of AW+1 bits gives the wrap.
  always_comb begin
    ptr_d  = ptr_q;
    ptr_en = 1'b0;
    if (clr) begin
      ptr_d  = '0;
      ptr_en = 1'b1;
    end else if (inc) begin
      ptr_d  = ptr_q + {{AW{1'b0}}, 1'b1};
      ptr_en = 1'b1;
    end else begin
      ptr_d  = ptr_q;
      ptr_en = 1'b0;
    end
  end

  gnl_dffre #(.W(AW + 1), .RV('0)) u_ptr_q (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ptr_en),
    .d    (ptr_d),
    .q    (ptr_q)
  );

  assign ptr = ptr_q;

endmodule

// File: rtl/gnl_sync_fifo.sv
// Synchronous valid/ready FIFO with first-word fall-through output.
// Full/empty come only from registered pointers, so ready/valid never see a combinational path.
module gnl_sync_fifo
  import gnl_sync_fifo_pkg::*;
#(
  parameter int DW = GNL_DW_DEF,
  parameter int DP = GNL_DP_DEF,
  parameter int AW = gnl_aw(DP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [AW:0]   o_cnt
);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [DP-1:0] mem_we;
  logic [DW-1:0] mem_q [DP];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign i_rdy = !full;
  assign o_vld = !empty;
  assign push  = i_vld && i_rdy && !flush;
  assign pop   = o_vld && o_rdy && !flush;
  assign o_cnt = wr_ptr - rd_ptr;
  assign o_dat = mem_q[rd_ptr[AW-1:0]];

  gnl_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .inc  (push),
    .ptr  (wr_ptr)
  );

  gnl_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .inc  (pop),
    .ptr  (rd_ptr)
  );

  // One-hot write enable for the entry at the write index.
  always_comb begin
    mem_we = '0;
    if (push) begin
      mem_we[wr_ptr[AW-1:0]] = 1'b1;
    end else begin
      mem_we = '0;
    end
  end

  for (genvar gi = 0; gi < DP; gi++) begin : g_mem
    gnl_dffe #(.W(DW)) u_mem_q (
      .clk(clk),
      .en (mem_we[gi]),
      .d  (i_dat),
      .q  (mem_q[gi])
    );
  end

endmodule

// File: tb/tb_gnl_sync_fifo.sv
// Directed bench for gnl_sync_fifo (DP=4, DW=32) with hand-computed expectations.
module tb_gnl_sync_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        i_vld;
  logic        i_rdy;
  logic [31:0] i_dat;
  logic        o_vld;
  logic        o_rdy;
  logic [31:0] o_dat;
  logic [2:0]  o_cnt;

  int n_chk;
  int n_err;

  gnl_sync_fifo #(.DW(32), .DP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .i_vld(i_vld),
    .i_rdy(i_rdy),
    .i_dat(i_dat),
    .o_vld(o_vld),
    .o_rdy(o_rdy),
    .o_dat(o_dat),
    .o_cnt(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] d);
    i_vld = 1'b1;
    i_dat = d;
    step();
    i_vld = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    i_vld = 1'b0;
    i_dat = 32'h0;
    o_rdy = 1'b0;
    #12;
    chk("rst_o_vld", {31'b0, o_vld}, 32'd0);
    chk("rst_i_rdy", {31'b0, i_rdy}, 32'd1);
    chk("rst_o_cnt", {29'b0, o_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_o_vld", {31'b0, o_vld}, 32'd0);

    // Fill to full with no pops.
    push1(32'h11);
    chk("fill1_cnt", {29'b0, o_cnt}, 32'd1);
    chk("fill1_dat", o_dat, 32'h11);
    push1(32'h22);
    push1(32'h33);
    chk("fill3_rdy", {31'b0, i_rdy}, 32'd1);
    push1(32'h44);
    chk("full_i_rdy", {31'b0, i_rdy}, 32'd0);
    chk("full_cnt", {29'b0, o_cnt}, 32'd4);
    chk("full_dat", o_dat, 32'h11);

    // From full: first edge pops only, next edge push+pop.
    o_rdy = 1'b1;
    i_vld = 1'b1;
    i_dat = 32'h55;
    step();
    chk("pop_only_cnt", {29'b0, o_cnt}, 32'd3);
    chk("pop_only_dat", o_dat, 32'h22);
    chk("pop_only_rdy", {31'b0, i_rdy}, 32'd1);
    step();
    i_vld = 1'b0;
    chk("pushpop_cnt", {29'b0, o_cnt}, 32'd3);
    chk("pushpop_dat", o_dat, 32'h33);
    step();
    chk("drain_dat44", o_dat, 32'h44);
    chk("drain_cnt2", {29'b0, o_cnt}, 32'd2);
    step();
    chk("drain_dat55", o_dat, 32'h55);
    step();
    chk("drain_empty", {31'b0, o_vld}, 32'd0);
    chk("drain_cnt0", {29'b0, o_cnt}, 32'd0);

    // Single-word latency with o_rdy held high.
    chk("lat_pre_vld", {31'b0, o_vld}, 32'd0);
    push1(32'hA5);
    chk("lat_vld", {31'b0, o_vld}, 32'd1);
    chk("lat_dat", o_dat, 32'hA5);
    step();
    chk("lat_post_vld", {31'b0, o_vld}, 32'd0);

    // Streaming: prefill one word, then 20 push+pop cycles.
    o_rdy = 1'b0;
    push1(32'd0);
    o_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_vld = 1'b1;
      i_dat = 32'(k + 1);
      chk($sformatf("stream_dat%0d", k), o_dat, 32'(k));
      chk($sformatf("stream_rdy%0d", k), {31'b0, i_rdy}, 32'd1);
      step();
      chk($sformatf("stream_cnt%0d", k), {29'b0, o_cnt}, 32'd1);
    end
    i_vld = 1'b0;
    chk("stream_last", o_dat, 32'd20);
    step();
    chk("stream_drained", {29'b0, o_cnt}, 32'd0);

    // Flush with 3 entries overrides a simultaneous push and pop.
    o_rdy = 1'b0;
    push1(32'h61);
    push1(32'h62);
    push1(32'h63);
    chk("pre_flush_cnt", {29'b0, o_cnt}, 32'd3);
    flush = 1'b1;
    i_vld = 1'b1;
    i_dat = 32'h77;
    o_rdy = 1'b1;
    step();
    flush = 1'b0;
    i_vld = 1'b0;
    o_rdy = 1'b0;
    chk("flush_cnt", {29'b0, o_cnt}, 32'd0);
    chk("flush_o_vld", {31'b0, o_vld}, 32'd0);
    chk("flush_i_rdy", {31'b0, i_rdy}, 32'd1);
    push1(32'h88);
    chk("post_flush_dat", o_dat, 32'h88);
    chk("post_flush_cnt", {29'b0, o_cnt}, 32'd1);
    o_rdy = 1'b1;
    step();
    o_rdy = 1'b0;

    // Asynchronous reset mid-cycle with 2 entries.
    push1(32'h91);
    push1(32'h92);
    chk("pre_arst_cnt", {29'b0, o_cnt}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_o_vld", {31'b0, o_vld}, 32'd0);
    chk("arst_cnt", {29'b0, o_cnt}, 32'd0);
    chk("arst_i_rdy", {31'b0, i_rdy}, 32'd1);
    #1 rst_n = 1'b1;
    step();
    chk("post_arst_vld", {31'b0, o_vld}, 32'd0);
    push1(32'hC3);
    chk("post_arst_dat", o_dat, 32'hC3);
    chk("post_arst_cnt", {29'b0, o_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
